// File: rtl/sar_search_if.sv
// Handshake and comparator bundle between a successive-approximation
// searcher and its surroundings (requester plus external comparator).
interface sar_search_if #(
    parameter int WIDTH = 4
);
    localparam int SW = $clog2(WIDTH) + 1;

    logic             Start;
    logic             Abort;
    logic             Eq;
    logic             Gt;
    logic [WIDTH-1:0] Guess;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Found;
    logic [SW-1:0]    Steps;

    // Environment side: requests searches and answers comparisons.
    modport master (
        output Start, Abort, Eq, Gt,
        input  Guess, Busy, Done, Result, Found, Steps
    );

    // Searcher side.
    modport slave (
        input  Start, Abort, Eq, Gt,
        output Guess, Busy, Done, Result, Found, Steps
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unknown operand X one bit per
// probe using an external comparator that reports X==Guess and X>Guess.
// An equality hit ends the search early.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    sar_search_if.slave srch
);
    localparam int SW    = $clog2(WIDTH) + 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] guess;
    logic [WIDTH-1:0] partial;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] result;
    logic             found;
    logic [SW-1:0]    steps;
    logic             busy;
    logic             done;

    // Partial value after the current probe: the trial bit is kept when X lies
    // above the guess (guess is partial with that bit set, so reuse it).
    logic [WIDTH-1:0] partial_upd;

    // Resolve the current trial bit from the comparator.
    always_comb begin
        partial_upd = partial;
        if (srch.Gt) begin
            partial_upd = guess;
        end
    end

    // Search controller with registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            guess   <= '0;
            partial <= '0;
            idx     <= '0;
            result  <= '0;
            found   <= 1'b0;
            steps   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (srch.Start) begin
                        state   <= PROBE;
                        busy    <= 1'b1;
                        guess   <= MSB;
                        partial <= '0;
                        idx     <= IDX_W'(WIDTH - 1);
                        steps   <= '0;
                        found   <= 1'b0;
                    end
                end
                PROBE: begin
                    if (srch.Abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        steps <= steps + 1'b1;
                        if (srch.Eq) begin
                            result <= guess;
                            found  <= 1'b1;
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else if (idx != '0) begin
                            partial <= partial_upd;
                            guess   <= partial_upd | (ONE << (idx - 1'b1));
                            idx     <= idx - 1'b1;
                        end else begin
                            partial <= partial_upd;
                            result  <= partial_upd;
                            found   <= 1'b0;
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign srch.Guess  = guess;
    assign srch.Busy   = busy;
    assign srch.Done   = done;
    assign srch.Result = result;
    assign srch.Found  = found;
    assign srch.Steps  = steps;
endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the width of the searched operand, Guess and Result.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: request to begin a search, sampled only in IDLE.
REQ-005 SHALL have port Abort, input, 1 bit: cancels a search in progress.
REQ-006 SHALL have port Eq, input, 1 bit: comparator result, X equal to Guess, combinational from Guess.
REQ-007 SHALL have port Gt, input, 1 bit: comparator result, X greater than Guess, combinational from Guess.
REQ-008 SHALL have port Guess, output, WIDTH bits: registered trial value driven to the comparator Y operand.
REQ-009 SHALL have port Busy, output, 1 bit: high while in PROBE.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle completion pulse, high only in DONE.
REQ-011 SHALL have port Result, output, WIDTH bits: recovered X value, held from DONE until the next Start.
REQ-012 SHALL have port Found, output, 1 bit: high if the search ended on an Eq hit.
REQ-013 SHALL have port Steps, output, clog2(WIDTH)+1 bits: number of probes evaluated in the last search.

Function
REQ-014 SHALL implement the state machine IDLE -> PROBE -> DONE -> IDLE.
REQ-015 SHALL, in IDLE with Start=1 at a clock edge, enter PROBE with Guess = MSB-only value (8 for WIDTH=4), internal partial = 0, bit index = WIDTH-1, Steps = 0, Found = 0.
REQ-016 SHALL evaluate exactly one probe per PROBE clock edge, incrementing Steps by 1.
REQ-017 SHALL give Eq priority: when Eq=1, Result = Guess, Found = 1, and the next state is DONE, regardless of Gt.
REQ-018 SHALL, when Eq=0 and Gt=1, keep the current bit in the partial value; when Eq=0 and Gt=0, clear that bit.
REQ-019 SHALL, when Eq=0 and the bit index > 0, set the next Guess = updated partial OR (1 << (index-1)) and decrement the index.
REQ-020 SHALL, when Eq=0 and the bit index = 0, set Result = updated partial, Found = 0, and go to DONE.
REQ-021 SHALL bound latency from the Start edge to the first Done cycle to 1 to WIDTH probe edges (at most WIDTH+1 edges after Start).
REQ-022 SHALL hold DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-023 SHALL ignore Start while in PROBE or DONE, and SHALL ignore Start and Abort when both are asserted in IDLE only as far as Abort is concerned, so Start wins in IDLE.
REQ-024 SHALL, on Abort=1 in PROBE, go to IDLE without pulsing Done, leaving Result and Found at their prior values.
REQ-025 SHALL hold Guess at its last driven value in IDLE and DONE.
REQ-026 SHALL assume X stable during a search; with X held stable, Result SHALL equal X.

Reset
REQ-027 SHALL, on Reset=1, immediately force state IDLE, Guess=0, Result=0, Found=0, Steps=0, Busy=0, Done=0, independent of Clock.
REQ-028 SHALL, when reset is asserted mid-PROBE, discard the search with no Done pulse, and the first Start after release SHALL begin a fresh search.

Verification
REQ-029 SHALL verify X=0: Guess sequence 8,4,2,1 -> Done after 4 probes, Result=0, Found=0, Steps=4.
REQ-030 SHALL verify X=8: first probe hits Eq -> Done after 1 probe, Result=8, Found=1, Steps=1.
REQ-031 SHALL verify X=5 and X=15: Guess sequences 8,4,6,5 and 8,12,14,15, each ending on an Eq hit with Found=1, Steps=4.
REQ-032 SHALL verify Start pulsed during PROBE at X=3: the search is unaffected, Result=3, and exactly one Done pulse occurs.
REQ-033 SHALL verify Abort after the 2nd probe, and Reset after the 2nd probe: no Done pulse, the state returns to IDLE, and all outputs equal their reset values in the Reset case.
REQ-034 SHALL verify an exhaustive sweep over X=0..15: Result==X for every value, and Steps <= 4 for every value.
